fc_layer_ctrl: RTL and testbench
================================

Name: fc_layer_ctrl

Overview:
- Control FSM for the fully connected layer datapath (fc_M_N_T_R_P family).
- Sequences three phases per input vector:
  - load N input values into the vector memory;
  - run grouped MAC passes over the weight ROMs, P output neurons per group;
  - drain the P accumulator lanes one at a time over the output handshake.
- Owns all external valid/ready signalling; the datapath holds only memories, MACs, optional ReLU and the output mux.

Parameters:
- M, 13, output neurons per vector; M % P == 0 is required.
- N, 16, input values per vector.
- P, 1, parallel MAC lanes.
- XW, $clog2(N), vector memory address width (minimum 1).
- WW, $clog2(M*N/P), per-lane weight ROM address width (minimum 1).
- LW, $clog2(P), lane select width (minimum 1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- input_valid  in  1  upstream data valid
- input_ready  out  1  controller accepts an input value
- output_valid  out  1  output_data on the datapath mux is valid
- output_ready  in  1  downstream accepts output
- x_wr_en  out  1  vector memory write enable
- x_addr  out  XW  vector memory address (write in LOAD, read in COMPUTE)
- w_addr  out  WW  weight ROM address, shared by all lanes
- acc_clr  out  1  clear all lane accumulators
- mac_en  out  1  accumulate product of data read last cycle
- out_sel  out  LW  lane driven onto output_data

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset value:
  - state = LOAD; all counters = 0.
  - All registered outputs = 0.
  - input_ready = 0 while reset is high.
- Memory model: x and w memories have 1-cycle read latency, registered address to data.
- LOAD:
  - input_ready = 1.
  - x_wr_en = input_valid & input_ready; x_addr = ld_cnt.
  - Each handshake increments ld_cnt.
  - Handshake at ld_cnt == N-1: ld_cnt <= 0, grp <= 0, go to COMPUTE.
- COMPUTE: lasts exactly N+1 cycles, counted by k = 0..N.
  - Cycle k=0: acc_clr = 1.
  - For k < N: x_addr = k and w_addr = grp*N + k are issued.
  - For 1 <= k <= N: mac_en = 1.
  - At k == N, go to DRAIN with lane = 0.
  - acc_clr and mac_en are never both high in the same cycle.
  - input_ready = 0 and output_valid = 0 throughout.
- DRAIN:
  - output_valid = 1; out_sel = lane.
  - On output_ready, lane increments.
  - Handshake at lane == P-1:
    - if grp < M/P-1: grp++, go to COMPUTE with k = 0;
    - otherwise go to LOAD.
  - Without output_ready, all outputs hold. output_valid never drops before its handshake.
- Latency:
  - First output_valid is N+1 cycles after the edge accepting the last input. Default: 17 cycles.
  - Output order is neuron index 0..M-1: group-major, lane-minor.
- No overlap of phases: input_ready is low from the last input accept until the final output handshake of the vector.
- Reset mid-operation (any state): immediate return to reset values. The partial vector is discarded and the next accepted value is element 0.
- input_valid held with no handshake possible (outside LOAD): ignored.
- Widths: counters are sized to hold N, P and M/P exactly. w_addr must reach M*N/P-1 without overflow. Default maximum is 207.

Decomposition:
- Package fc_ctrl_pkg:
  - typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} fc_state_t;
  - helper function clog2_min1().
- One sub-module, fc_addr_gen: k counter plus w_addr = grp*N + k, implemented with an incrementing base register (no multiplier).

Test Plan:
- Default params, input_valid held high, output_ready held high; 16 inputs.
  - input_ready drops after 16 accepts.
  - 17 cycles later output_valid = 1.
  - 13 outputs drain back-to-back, with 17 COMPUTE cycles between each.
  - input_ready then returns.
- Address trace, group 2: w_addr steps 32..47 while mac_en is high on the 16 cycles following acc_clr; x_addr steps 0..15.
- output_ready low for 5 cycles during DRAIN: output_valid, out_sel and state are stable; exactly one output per handshake.
- P=4, M=12, N=8:
  - out_sel sequence 0,1,2,3 per group, 3 groups;
  - w_addr range 0..23;
  - 12 outputs per vector.
- Reset asserted asynchronously mid-COMPUTE (k=7), without a clock edge: state returns to LOAD, acc_clr/mac_en/output_valid = 0. After release, 16 fresh inputs produce a normal result.
- Random input_valid/output_ready over 625 vectors (10000 inputs, 8125 outputs) with the fc datapath behavioural model: zero mismatches.

Source files
------------

// File: rtl/fc_ctrl_pkg.sv
// Shared definitions for the fully connected layer controller.
//   fc_state_t   : LOAD (fill vector memory), COMPUTE (one MAC pass over
//                  a group of P neurons), DRAIN (hand out the P lanes)
//   clog2_min1() : ceil(log2(v)), never below 1, used for address and
//                  select widths that must stay legal for degenerate sizes
package fc_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    DRAIN
  } fc_state_t;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// COMPUTE-phase address generator.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   i_run       : controller is in COMPUTE; k counts 0..N while high
//   i_base_clr  : restart at group 0 (base = 0)
//   i_base_inc  : advance to the next group (base += N)
//   o_k         : current MAC-pass step, 0..N
//   o_issue     : k < N, an x/w read address is being issued
//   o_k_last    : k == N, final accumulate step of the pass
//   o_w_addr    : shared weight ROM address, grp*N + k
module fc_addr_gen
  import fc_ctrl_pkg::*;
#(
  parameter int unsigned N  = 16,
  parameter int unsigned WW = 8,
  parameter int unsigned KW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_run,
  input  logic          i_base_clr,
  input  logic          i_base_inc,
  output logic [KW-1:0] o_k,
  output logic          o_issue,
  output logic          o_k_last,
  output logic [WW-1:0] o_w_addr
);

  logic [KW-1:0] r_k;
  logic [WW-1:0] r_base;
  logic [WW-1:0] w_k_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k <= '0;
    end else if (!i_run || o_k_last) begin
      // k is parked at 0 outside COMPUTE so every pass starts with acc_clr
      r_k <= '0;
    end else begin
      r_k <= r_k + KW'(1);
    end
  end

  // grp*N kept as a running base; it is never advanced past the last group,
  // so it cannot exceed M*N/P - N.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base <= '0;
    end else if (i_base_clr) begin
      r_base <= '0;
    end else if (i_base_inc) begin
      r_base <= r_base + WW'(N);
    end
  end

  always_comb begin
    o_k      = r_k;
    o_issue  = (r_k < KW'(N));
    o_k_last = (r_k == KW'(N));
    w_k_ext  = o_issue ? WW'(r_k) : '0;
    o_w_addr = r_base + w_k_ext;
  end

endmodule

// File: rtl/fc_layer_ctrl.sv
// Control FSM for the fc_M_N_T_R_P datapath: loads N inputs, runs M/P
// grouped MAC passes of N+1 cycles each, drains P lanes per group.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   input_valid / input_ready  : upstream handshake (LOAD only)
//   output_valid / output_ready: downstream handshake (DRAIN only)
//   x_wr_en, x_addr            : vector memory write enable / address
//   w_addr                     : weight ROM address shared by all lanes
//   acc_clr, mac_en            : accumulator clear / accumulate strobes
//   out_sel                    : lane routed onto output_data
module fc_layer_ctrl
  import fc_ctrl_pkg::*;
#(
  parameter int unsigned M  = 13,
  parameter int unsigned N  = 16,
  parameter int unsigned P  = 1,
  parameter int unsigned XW = clog2_min1(N),
  parameter int unsigned WW = clog2_min1(M * N / P),
  parameter int unsigned LW = clog2_min1(P)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          input_valid,
  output logic          input_ready,
  output logic          output_valid,
  input  logic          output_ready,
  output logic          x_wr_en,
  output logic [XW-1:0] x_addr,
  output logic [WW-1:0] w_addr,
  output logic          acc_clr,
  output logic          mac_en,
  output logic [LW-1:0] out_sel
);

  localparam int unsigned G  = M / P;
  localparam int unsigned GW = clog2_min1(G);
  localparam int unsigned KW = $clog2(N + 1);

  fc_state_t     r_state;
  fc_state_t     w_state_nxt;
  logic [XW-1:0] r_ld_cnt;
  logic [GW-1:0] r_grp;
  logic [LW-1:0] r_lane;

  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_ld_last;
  logic          w_lane_last;
  logic          w_grp_last;
  logic          w_ld_done;
  logic          w_grp_inc;
  logic          w_run;

  logic [KW-1:0] w_k;
  logic          w_issue;
  logic          w_k_last;
  logic [WW-1:0] w_w_addr;

  fc_addr_gen #(
    .N  (N),
    .WW (WW),
    .KW (KW)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .i_run      (w_run),
    .i_base_clr (w_ld_done),
    .i_base_inc (w_grp_inc),
    .o_k        (w_k),
    .o_issue    (w_issue),
    .o_k_last   (w_k_last),
    .o_w_addr   (w_w_addr)
  );

  assign w_ld_last   = (r_ld_cnt == XW'(N - 1));
  assign w_lane_last = (r_lane == LW'(P - 1));
  assign w_grp_last  = (r_grp == GW'(G - 1));
  assign w_run       = (r_state == COMPUTE);
  assign w_addr      = w_w_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    x_wr_en      = 1'b0;
    x_addr       = '0;
    acc_clr      = 1'b0;
    mac_en       = 1'b0;
    out_sel      = '0;
    w_in_hs      = 1'b0;
    w_out_hs     = 1'b0;
    w_ld_done    = 1'b0;
    w_grp_inc    = 1'b0;

    unique case (r_state)
      LOAD: begin
        // reset holds the state in LOAD, so ready is masked explicitly
        input_ready = ~reset;
        w_in_hs     = input_valid & ~reset;
        x_wr_en     = w_in_hs;
        x_addr      = r_ld_cnt;
        if (w_in_hs && w_ld_last) begin
          w_ld_done   = 1'b1;
          w_state_nxt = COMPUTE;
        end
      end

      COMPUTE: begin
        // k=0 clears, k=1..N accumulate the read issued one cycle earlier
        acc_clr = (w_k == '0);
        mac_en  = (w_k != '0);
        x_addr  = w_issue ? XW'(w_k) : '0;
        if (w_k_last) begin
          w_state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        output_valid = 1'b1;
        out_sel      = r_lane;
        w_out_hs     = output_ready;
        if (w_out_hs && w_lane_last) begin
          if (w_grp_last) begin
            w_state_nxt = LOAD;
          end else begin
            w_grp_inc   = 1'b1;
            w_state_nxt = COMPUTE;
          end
        end
      end

      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_cnt <= '0;
      r_grp    <= '0;
      r_lane   <= '0;
    end else begin
      if (w_in_hs) begin
        r_ld_cnt <= w_ld_last ? '0 : r_ld_cnt + XW'(1);
      end
      if (w_ld_done) begin
        r_grp <= '0;
      end else if (w_grp_inc) begin
        r_grp <= r_grp + GW'(1);
      end
      if (w_out_hs) begin
        r_lane <= w_lane_last ? '0 : r_lane + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
`timescale 1ns/1ps
module tb_fc_layer_ctrl;
  import fc_ctrl_pkg::*;

  localparam int MA = 13, NA = 16, PA = 1;
  localparam int MB = 12, NB = 8,  PB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: default parameters
  logic       a_iv = 1'b0, a_or = 1'b0;
  logic       a_ir, a_ov, a_we, a_clr, a_mac;
  logic [3:0] a_xa;
  logic [7:0] a_wa;
  logic [0:0] a_sel;
  // DUT B: M=12, N=8, P=4
  logic       b_iv = 1'b0, b_or = 1'b0;
  logic       b_ir, b_ov, b_we, b_clr, b_mac;
  logic [2:0] b_xa;
  logic [4:0] b_wa;
  logic [1:0] b_sel;

  fc_layer_ctrl #(.M(MA), .N(NA), .P(PA)) dut_a (
    .clk(clk), .reset(rst),
    .input_valid(a_iv), .input_ready(a_ir),
    .output_valid(a_ov), .output_ready(a_or),
    .x_wr_en(a_we), .x_addr(a_xa), .w_addr(a_wa),
    .acc_clr(a_clr), .mac_en(a_mac), .out_sel(a_sel)
  );

  fc_layer_ctrl #(.M(MB), .N(NB), .P(PB)) dut_b (
    .clk(clk), .reset(rst),
    .input_valid(b_iv), .input_ready(b_ir),
    .output_valid(b_ov), .output_ready(b_or),
    .x_wr_en(b_we), .x_addr(b_xa), .w_addr(b_wa),
    .acc_clr(b_clr), .mac_en(b_mac), .out_sel(b_sel)
  );

  int nvec = 0, nfail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Weight matrix W[j][i]; lane l's ROM holds row g*P+l at address g*N+i.
  function automatic int wt(input int j, input int i);
    return ((j * 7 + i * 5 + 3) % 13) - 6;
  endfunction

  function automatic int rom(input int l, input int a, input int m, input int n, input int p);
    int j;
    j = (a / n) * p + l;
    return (j < m) ? wt(j, a % n) : 0;
  endfunction

  // Behavioural datapath plus protocol expectations, one set per DUT
  int xmem [2][16];
  int xq   [2];
  int wq   [2][4];
  int acc  [2][4];
  int ldv  [2][16];
  int ld_n [2];
  int cur_in [2];
  bit in_vec [2];
  int ov_from [2];
  int cs [2];
  int out_idx [2];
  int n_out [2];
  int n_done [2];
  bit p_ov [2], p_or [2];
  int p_sel [2];
  int expq_a [$];
  int expq_b [$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      in_vec[d] = 1'b0; ov_from[d] = -1; cs[d] = -1; out_idx[d] = 0; ld_n[d] = 0;
      xq[d] = 0; p_ov[d] = 1'b0; p_or[d] = 1'b0; p_sel[d] = 0;
      for (int l = 0; l < 4; l++) begin acc[d][l] = 0; wq[d][l] = 0; end
    end
    expq_a.delete();
    expq_b.delete();
  endtask

  // Called at the falling edge: everything sampled is what the next rising edge sees.
  task automatic tick(input int d);
    int m, n, p, xa, wa, sel, k, y, s;
    bit iv, ir, ov, orr, we, clr, mac, e_ov;
    if (d == 0) begin
      m = MA; n = NA; p = PA;
      iv = a_iv; ir = a_ir; ov = a_ov; orr = a_or; we = a_we; clr = a_clr; mac = a_mac;
      xa = int'(a_xa); wa = int'(a_wa); sel = int'(a_sel);
    end else begin
      m = MB; n = NB; p = PB;
      iv = b_iv; ir = b_ir; ov = b_ov; orr = b_or; we = b_we; clr = b_clr; mac = b_mac;
      xa = int'(b_xa); wa = int'(b_wa); sel = int'(b_sel);
    end

    e_ov = (ov_from[d] >= 0) && (cyc >= ov_from[d]);
    chk("output_valid", int'(ov), int'(e_ov));
    chk("input_ready", int'(ir), int'(!in_vec[d]));
    chk("x_wr_en", int'(we), int'(iv && !in_vec[d]));
    k = (cs[d] >= 0) ? cyc - cs[d] : -1;
    chk("acc_clr", int'(clr), int'(k == 0));
    chk("mac_en", int'(mac), int'(k >= 1 && k <= n));
    if (k >= 0 && k < n) begin
      chk("x_addr_rd", xa, k);
      chk("w_addr", wa, (out_idx[d] / p) * n + k);
    end
    if (p_ov[d] && !p_or[d]) chk("out_sel_hold", sel, p_sel[d]);

    if (iv && ir) begin
      chk("x_addr_wr", xa, ld_n[d]);
      xmem[d][xa] = cur_in[d];
      ldv[d][ld_n[d]] = cur_in[d];
      ld_n[d]++;
      cur_in[d] = int'($urandom_range(0, 255)) - 128;
      if (ld_n[d] == n) begin
        for (int j = 0; j < m; j++) begin
          s = 0;
          for (int i = 0; i < n; i++) s += wt(j, i) * ldv[d][i];
          if (d == 0) expq_a.push_back(s); else expq_b.push_back(s);
        end
        ld_n[d] = 0; in_vec[d] = 1'b1;
        cs[d] = cyc + 1; ov_from[d] = cyc + n + 2;
      end
    end

    if (ov && orr) begin
      chk("out_sel", sel, out_idx[d] % p);
      if ((d == 0 && expq_a.size() == 0) || (d == 1 && expq_b.size() == 0)) begin
        chk("spurious_output", 1, 0);
      end else begin
        y = (d == 0) ? expq_a.pop_front() : expq_b.pop_front();
        chk("output_data", acc[d][sel], y);
      end
      n_out[d]++;
      if (out_idx[d] % p == p - 1) begin
        if (out_idx[d] == m - 1) begin
          in_vec[d] = 1'b0; ov_from[d] = -1; out_idx[d] = 0; n_done[d]++;
        end else begin
          out_idx[d]++; cs[d] = cyc + 1; ov_from[d] = cyc + n + 2;
        end
      end else begin
        out_idx[d]++; ov_from[d] = cyc + 1;
      end
    end

    // 1-cycle read latency memories feeding P accumulators
    for (int l = 0; l < p; l++) begin
      if (mac) acc[d][l] += xq[d] * wq[d][l];
      if (clr) acc[d][l] = 0;
    end
    xq[d] = xmem[d][xa];
    for (int l = 0; l < p; l++) wq[d][l] = rom(l, wa, m, n, p);

    p_ov[d] = ov; p_or[d] = orr; p_sel[d] = sel;
  endtask

  task automatic drive(input int d, input int ivp, input int orp);
    logic v, r;
    v = (int'($urandom_range(0, 99)) < ivp);
    r = (int'($urandom_range(0, 99)) < orp);
    if (d == 0) begin a_iv = v; a_or = r; end
    else        begin b_iv = v; b_or = r; end
  endtask

  task automatic idle();
    a_iv = 1'b0; a_or = 1'b0; b_iv = 1'b0; b_or = 1'b0;
  endtask

  task automatic step(input int d, input int ivp, input int orp);
    @(posedge clk); #1; drive(d, ivp, orp);
    @(negedge clk); tick(d);
  endtask

  task automatic run(input int d, input int ivp, input int orp, input int nv, output int outs);
    int sd, so, t, budget;
    sd = n_done[d]; so = n_out[d]; t = 0; budget = nv * 2000 + 500;
    while ((n_done[d] - sd) < nv && t < budget) begin
      step(d, ivp, orp);
      t++;
    end
    if (t >= budget) chk("run_timeout", 0, 1);
    @(posedge clk); #1; idle();
    outs = n_out[d] - so;
  endtask

  typedef struct {
    int d;
    int ivp;
    int orp;
    int nv;
    int exp_outs;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int outs, t, s0, no0;
    bit found;

    tbl[0] = '{0, 100, 100, 1,   MA};
    tbl[1] = '{1, 100, 100, 1,   MB};
    tbl[2] = '{0,  70, 100, 2,   2 * MA};
    tbl[3] = '{1,  50,  50, 60,  60 * MB};
    tbl[4] = '{0,  50,  60, 110, 110 * MA};
    tbl[5] = '{0, 100,  30, 3,   3 * MA};

    for (int d = 0; d < 2; d++) begin
      n_out[d] = 0; n_done[d] = 0;
      cur_in[d] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 16; i++) xmem[d][i] = 0;
    end
    model_reset();

    // reset state, with input_valid asserted to show ready stays low
    rst = 1'b1; a_iv = 1'b1; b_iv = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_input_ready", int'(a_ir), 0);
    chk("rst_a_x_wr_en", int'(a_we), 0);
    chk("rst_a_output_valid", int'(a_ov), 0);
    chk("rst_a_acc_clr", int'(a_clr), 0);
    chk("rst_a_mac_en", int'(a_mac), 0);
    chk("rst_a_w_addr", int'(a_wa), 0);
    chk("rst_b_input_ready", int'(b_ir), 0);
    chk("rst_b_output_valid", int'(b_ov), 0);
    chk("rst_b_out_sel", int'(b_sel), 0);
    idle();
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run(tbl[v].d, tbl[v].ivp, tbl[v].orp, tbl[v].nv, outs);
      chk($sformatf("outputs_row%0d", v), outs, tbl[v].exp_outs);
    end

    // downstream stall on the first output of a vector
    found = 1'b0; t = 0;
    while (!found && t < 1000) begin
      step(0, 100, 0);
      t++;
      if (a_ov) found = 1'b1;
    end
    chk("stall_reach_drain", int'(found), 1);
    s0 = int'(a_sel); no0 = n_out[0];
    for (int i = 0; i < 5; i++) begin
      step(0, 100, 0);
      chk("stall_output_valid", int'(a_ov), 1);
      chk("stall_out_sel", int'(a_sel), s0);
      chk("stall_state", int'(dut_a.r_state), int'(DRAIN));
    end
    chk("stall_no_output", n_out[0], no0);
    run(0, 100, 100, 1, outs);
    chk("stall_outputs", outs, MA);

    // asynchronous reset at k=7 of the first MAC pass
    found = 1'b0; t = 0;
    while (!found && t < 1000) begin
      step(0, 100, 100);
      t++;
      if (in_vec[0] && out_idx[0] == 0 && cs[0] >= 0 && cyc - cs[0] == 7) found = 1'b1;
    end
    chk("reach_k7", int'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", int'(dut_a.r_state), int'(LOAD));
    chk("async_rst_acc_clr", int'(a_clr), 0);
    chk("async_rst_mac_en", int'(a_mac), 0);
    chk("async_rst_output_valid", int'(a_ov), 0);
    chk("async_rst_input_ready", int'(a_ir), 0);
    model_reset();
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(0, 100, 100, 1, outs);
    chk("post_reset_outputs", outs, MA);
    run(1, 100, 100, 1, outs);
    chk("post_reset_outputs_b", outs, MB);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
